// File: rtl/cnt_rd_if.sv
// Counter read interface: three-state read FSM with optional clear-on-read.
// Optional per-counter sticky wrap flags are enabled by defining CNT_RD_OVF_EN.
module cnt_rd_if #(
  parameter int CNT_NUM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_NUM*32-1:0]  cnt_d,
  output logic [CNT_NUM-1:0]     cnt_s_clr,
  input  logic                   rd_req,
  input  logic [3:0]             rd_addr,
  input  logic                   rd_clr,
  output logic                   rd_busy,
  output logic                   rd_ack,
  output logic [31:0]            rd_data,
  output logic                   rd_err,
  output logic                   rd_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [4:0] CNT_NUM_W = 5'(CNT_NUM);

  state_t               state_r;
  logic [3:0]           addr_r;
  logic                 in_range_r;
  logic                 busy_r;
  logic                 ack_r;
  logic [31:0]          data_r;
  logic                 err_r;
  logic                 ovf_r;
  logic [CNT_NUM-1:0]   s_clr_r;

  logic                 req_in_range_s;
  logic [31:0]          cnt_arr_s [16];
  logic [31:0]          sel_data_s;
  logic                 sel_ovf_s;

  // Pad the counter bus to 16 entries so any 4-bit index selects safely.
  for (genvar g = 0; g < 16; g++) begin : g_pad
    if (g < CNT_NUM) begin : g_real
      assign cnt_arr_s[g] = cnt_d[g*32 +: 32];
    end else begin : g_zero
      assign cnt_arr_s[g] = 32'h0;
    end
  end

  assign req_in_range_s = ({1'b0, rd_addr} < CNT_NUM_W);
  assign sel_data_s     = cnt_arr_s[addr_r];

`ifdef CNT_RD_OVF_EN
  logic [CNT_NUM-1:0] msb_r;
  logic [CNT_NUM-1:0] clr_d_r;
  logic [CNT_NUM-1:0] flag_r;
  logic [CNT_NUM-1:0] msb_s;
  logic [CNT_NUM-1:0] wrap_s;
  logic [15:0]        flag_pad_s;

  // Wrap = bit 31 falling, ignoring the drop caused by our own clear pulse.
  always_comb begin
    msb_s = '0;
    for (int i = 0; i < CNT_NUM; i++) begin
      msb_s[i] = cnt_d[i*32 + 31];
    end
    wrap_s     = msb_r & ~msb_s & ~clr_d_r;
    flag_pad_s = 16'(flag_r);
    sel_ovf_s  = flag_pad_s[addr_r];
  end

  // Sticky flags: a clear-read clears at the latch edge, a new wrap wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_r   <= '0;
      clr_d_r <= '0;
      flag_r  <= '0;
    end else begin
      msb_r   <= msb_s;
      clr_d_r <= s_clr_r;
      flag_r  <= wrap_s | (flag_r & ~s_clr_r);
    end
  end
`else
  assign sel_ovf_s = 1'b0;
`endif

  // Read FSM with registered handshake, data and clear pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      addr_r     <= 4'd0;
      in_range_r <= 1'b0;
      busy_r     <= 1'b0;
      ack_r      <= 1'b0;
      data_r     <= 32'h0;
      err_r      <= 1'b0;
      ovf_r      <= 1'b0;
      s_clr_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r   <= 1'b0;
          s_clr_r <= '0;
          if (rd_req) begin
            state_r    <= LATCH;
            addr_r     <= rd_addr;
            in_range_r <= req_in_range_s;
            busy_r     <= 1'b1;
            if (rd_clr && req_in_range_s) begin
              s_clr_r <= {{(CNT_NUM-1){1'b0}}, 1'b1} << rd_addr;
            end else begin
              s_clr_r <= '0;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        LATCH: begin
          state_r <= ACK;
          s_clr_r <= '0;
          ack_r   <= 1'b1;
          data_r  <= in_range_r ? sel_data_s : 32'h0;
          err_r   <= ~in_range_r;
          ovf_r   <= in_range_r & sel_ovf_s;
        end
        ACK: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          s_clr_r <= '0;
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          s_clr_r <= '0;
        end
      endcase
    end
  end

  assign cnt_s_clr = s_clr_r;
  assign rd_busy   = busy_r;
  assign rd_ack    = ack_r;
  assign rd_data   = data_r;
  assign rd_err    = err_r;
  assign rd_ovf    = ovf_r;

endmodule

// File: doc/cnt_rd_if.md
CNT_RD_IF -- requirements
Module: cnt_rd_if

Interface
REQ-001 SHALL provide parameter CNT_NUM, default 8, number of attached 32-bit counters (legal 2..16).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cnt_d, input, CNT_NUM*32, live counter values; counter i at bits [32i+31:32i].
REQ-006 SHALL have port cnt_s_clr, output, CNT_NUM, one-cycle synchronous clear pulses to the counters.
REQ-007 SHALL have port rd_req, input, 1, single-cycle read request.
REQ-008 SHALL have port rd_addr, input, 4, counter index.
REQ-009 SHALL have port rd_clr, input, 1, clear-on-read qualifier.
REQ-010 SHALL have port rd_busy, output, 1, high whenever the FSM is not IDLE.
REQ-011 SHALL have port rd_ack, output, 1, one-cycle response strobe.
REQ-012 SHALL have port rd_data, output, 32, read value, valid only with rd_ack.
REQ-013 SHALL have port rd_err, output, 1, out-of-range address flag, valid with rd_ack.
REQ-014 SHALL have port rd_ovf, output, 1, sticky wrap flag of the addressed counter, valid with rd_ack (CNT_RD_OVF_EN only; tied 0 otherwise).

Function
REQ-015 FSM states SHALL be IDLE, LATCH, ACK; transitions IDLE->LATCH on accepted rd_req, LATCH->ACK, ACK->IDLE unconditionally.
REQ-016 rd_req SHALL be accepted only in IDLE; rd_req while busy SHALL be ignored without side effect.
REQ-017 rd_addr and rd_clr SHALL be captured at the accepting edge (cycle T).
REQ-018 In cycle T+1 (LATCH), rd_data register SHALL load cnt_d of the captured index at the T+1 edge.
REQ-019 rd_ack SHALL be high exactly in cycle T+2, with rd_data/rd_err/rd_ovf stable; max throughput one read per 3 cycles.
REQ-020 If rd_clr captured and index in range, cnt_s_clr[index] SHALL be registered high in cycle T+1 only; all other bits 0.
REQ-021 Counter events in cycle T+1 of a clear-read are lost (clear has priority in the counter); accepted, not compensated.
REQ-022 Index >= CNT_NUM: rd_err=1, rd_data=32'h0, rd_ovf=0, no cnt_s_clr pulse.
REQ-023 rd_data, rd_err, rd_ovf SHALL hold last value outside rd_ack.

Reset
REQ-024 rst_n low SHALL force FSM to IDLE immediately; rd_busy, rd_ack, rd_err, rd_ovf, cnt_s_clr to 0; rd_data to 32'h0; all sticky flags to 0.
REQ-025 Reset mid-transaction SHALL abort it: no rd_ack, no cnt_s_clr pulse after rst_n deasserts.
REQ-026 First rd_req SHALL be accepted no earlier than the first rising edge with rst_n high.

Configuration
REQ-027 Macro CNT_RD_OVF_EN, when defined, SHALL add a per-counter sticky flag set when bit 31 of that counter goes 1->0 between consecutive cycles, excluding the cycle following its own cnt_s_clr pulse.
REQ-028 With CNT_RD_OVF_EN, a clear-read SHALL clear that counter's flag at the T+1 edge; a set in the same cycle SHALL win.
REQ-029 Without CNT_RD_OVF_EN, no flag storage SHALL exist and rd_ovf SHALL be constant 0.

Verification
REQ-030 Counter 3 = 32'h0000_1234 static, rd_req addr 3 clr 0 at T -> rd_ack at T+2, rd_data 32'h0000_1234, no cnt_s_clr.
REQ-031 Counter 5 = 32'h0001_0000, clear-read addr 5 -> cnt_s_clr = 8'h20 in T+1 only, rd_data 32'h0001_0000, counter reads 0 afterwards.
REQ-032 rd_req at T and T+1 -> second ignored, exactly one rd_ack; rd_req at T+3 accepted.
REQ-033 rd_addr 4'd9 with CNT_NUM=8, rd_clr=1 -> rd_ack at T+2, rd_err=1, rd_data 0, cnt_s_clr stays 0.
REQ-034 rst_n pulsed low in LATCH of a clear-read -> outputs 0 immediately, no rd_ack, no cnt_s_clr afterwards.
REQ-035 CNT_RD_OVF_EN: counter 0 wraps 32'hFFFF_FFFF->0, clear-read addr 0 -> rd_ovf=1; next read addr 0 -> rd_ovf=0.
